// File: rtl/cpu_types_pkg.sv
// Shared types for the MIPS core pipeline control logic.
package cpu_types_pkg;
  typedef logic [4:0] regbits_t;

  typedef enum logic {RUN = 1'b0, LU_STALL = 1'b1} hz_state_t;

  localparam logic [1:0] PC_SEQ = 2'b00;

  // Latch-control bundle driven by the hazard controller each cycle.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
  } hz_ctrl_t;

  localparam hz_ctrl_t HZ_IDLE   = '{default: 1'b0};
  localparam hz_ctrl_t HZ_RUN    = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1,
                                     exmem_en: 1'b1, memwb_en: 1'b1, default: 1'b0};
  // Hold PC and IF/ID, push a bubble into ID/EX, let the back end drain.
  localparam hz_ctrl_t HZ_BUBBLE = '{idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
                                     idex_flush: 1'b1, default: 1'b0};
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        count <= '0;
    else if (clr)                   count <= '0;
    else if (inc && (count != '1))  count <= count + 1'b1;
  end
endmodule

// File: rtl/hazard_ctrl_gen2.sv
// Pipeline hazard controller: load-use bubbles, redirect flushes, memory-wait
// freezes, plus saturating stall/flush performance counters.
module hazard_ctrl_gen2
  import cpu_types_pkg::*;
#(
  parameter int REG_W         = 5,
  parameter int LU_STALLS     = 1,
  parameter int RESOLVE_STAGE = 1,
  parameter int CNT_W         = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             idex_memread,
  input  logic [1:0]       pcsrc,
  input  logic             dmem_wait,
  input  logic             imem_wait,
  input  logic             cnt_clr,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int          LC_W    = 3;
  localparam logic [LC_W-1:0] LU_LOAD = LC_W'(LU_STALLS - 1);

  hz_state_t       state, state_nxt;
  logic [LC_W-1:0] lu_cnt, lu_cnt_nxt;
  hz_ctrl_t        ctl;
  logic            lu_hit, redirect, flush_inc;
  logic [1:0]      cnt_inc;
  logic [1:0][CNT_W-1:0] cnt_q;

  assign lu_hit = idex_memread && (idex_rt != '0) &&
                  ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
  assign redirect = (pcsrc != PC_SEQ);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= RUN;
      lu_cnt <= '0;
    end else begin
      state  <= state_nxt;
      lu_cnt <= lu_cnt_nxt;
    end
  end

  always_comb begin
    ctl        = HZ_IDLE;
    state_nxt  = state;
    lu_cnt_nxt = lu_cnt;
    flush_inc  = 1'b0;
    if (RST) begin
      ctl = HZ_IDLE;
    end else if (dmem_wait) begin
      ctl = HZ_IDLE;
    end else if (redirect) begin
      ctl            = HZ_RUN;
      ctl.ifid_flush = 1'b1;
      ctl.idex_flush = (RESOLVE_STAGE == 2);
      state_nxt      = RUN;
      lu_cnt_nxt     = '0;
      flush_inc      = 1'b1;
    end else if ((state == LU_STALL) || lu_hit) begin
      ctl = HZ_BUBBLE;
      // Hits seen while already stalling are covered by the running bubble train.
      if (state == LU_STALL) begin
        if (lu_cnt == LC_W'(1)) begin
          state_nxt  = RUN;
          lu_cnt_nxt = '0;
        end else begin
          lu_cnt_nxt = lu_cnt - 1'b1;
        end
      end else if (LU_STALLS > 1) begin
        state_nxt  = LU_STALL;
        lu_cnt_nxt = LU_LOAD;
      end
    end else if (imem_wait) begin
      ctl = HZ_BUBBLE;
    end else begin
      ctl = HZ_RUN;
    end
  end

  assign pc_en      = ctl.pc_en;
  assign ifid_en    = ctl.ifid_en;
  assign idex_en    = ctl.idex_en;
  assign exmem_en   = ctl.exmem_en;
  assign memwb_en   = ctl.memwb_en;
  assign ifid_flush = ctl.ifid_flush;
  assign idex_flush = ctl.idex_flush;

  assign cnt_inc = {flush_inc, ~ctl.pc_en};

  for (genvar i = 0; i < 2; i++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (CLK),
      .rst   (RST),
      .inc   (cnt_inc[i]),
      .clr   (cnt_clr),
      .count (cnt_q[i])
    );
  end

  assign stall_cnt = cnt_q[0];
  assign flush_cnt = cnt_q[1];
endmodule

// File: tb/tb_hazard_ctrl_gen2.sv
// Directed bench: three parameter variants share one stimulus stream and are
// checked every cycle against a bubble-count model plus literal spot checks.
module tb_hazard_ctrl_gen2;
  localparam int NDUT = 3;
  localparam int LU_P [NDUT] = '{1, 3, 3};
  localparam int RS_P [NDUT] = '{1, 2, 1};
  localparam int CW_P [NDUT] = '{16, 16, 4};

  typedef struct packed {
    logic       mr;
    logic [4:0] ex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic [1:0] pc;
    logic       dw;
    logic       iw;
    logic       clr;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [4:0] ifid_rs = '0, ifid_rt = '0, idex_rt = '0;
  logic       ifid_uses_rt = 1'b0, idex_memread = 1'b0;
  logic [1:0] pcsrc = '0;
  logic       dmem_wait = 1'b0, imem_wait = 1'b0, cnt_clr = 1'b0;

  logic [6:0]  ctl_w [NDUT];
  logic [15:0] sc_w  [NDUT];
  logic [15:0] fc_w  [NDUT];

  int nvec = 0;
  int nmis = 0;
  int rem  [NDUT];
  int sc_m [NDUT];
  int fc_m [NDUT];

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    logic [CW_P[g]-1:0] sc_l, fc_l;
    hazard_ctrl_gen2 #(
      .REG_W(5), .LU_STALLS(LU_P[g]), .RESOLVE_STAGE(RS_P[g]), .CNT_W(CW_P[g])
    ) u_dut (
      .CLK(CLK), .RST(RST),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
      .idex_rt(idex_rt), .idex_memread(idex_memread), .pcsrc(pcsrc),
      .dmem_wait(dmem_wait), .imem_wait(imem_wait), .cnt_clr(cnt_clr),
      .pc_en(ctl_w[g][6]), .ifid_en(ctl_w[g][5]), .idex_en(ctl_w[g][4]),
      .exmem_en(ctl_w[g][3]), .memwb_en(ctl_w[g][2]),
      .ifid_flush(ctl_w[g][1]), .idex_flush(ctl_w[g][0]),
      .stall_cnt(sc_l), .flush_cnt(fc_l)
    );
    assign sc_w[g] = 16'(sc_l);
    assign fc_w[g] = 16'(fc_l);
  end

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit hazard_m();
    return idex_memread && (idex_rt != 0) &&
           ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
  endfunction

  // Expected {pc,ifid,idex,exmem,memwb,ifid_flush,idex_flush}; rem[k] is the
  // number of bubble cycles still owed after the current one.
  function automatic logic [6:0] model_out(input int k);
    if (RST)                        return 7'b0000000;
    if (dmem_wait)                  return 7'b0000000;
    if (pcsrc != 0)                 return {5'b11111, 1'b1, RS_P[k] == 2};
    if (rem[k] > 0 || hazard_m())   return 7'b0011101;
    if (imem_wait)                  return 7'b0011101;
    return 7'b1111100;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < NDUT; k++) begin
        rem[k] = 0; sc_m[k] = 0; fc_m[k] = 0;
      end
    end else begin
      for (int k = 0; k < NDUT; k++) begin
        logic [6:0] e;
        int mx;
        e  = model_out(k);
        mx = (1 << CW_P[k]) - 1;
        if (!dmem_wait) begin
          if (pcsrc != 0)       rem[k] = 0;
          else if (rem[k] > 0)  rem[k] = rem[k] - 1;
          else if (hazard_m())  rem[k] = LU_P[k] - 1;
        end
        if (cnt_clr) begin
          sc_m[k] = 0; fc_m[k] = 0;
        end else begin
          if (!e[6] && sc_m[k] < mx) sc_m[k]++;
          if (!dmem_wait && pcsrc != 0 && fc_m[k] < mx) fc_m[k]++;
        end
      end
    end
  end

  always @(negedge CLK) begin
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("ctl[%0d]", k), ctl_w[k], model_out(k));
      chk($sformatf("stall_cnt[%0d]", k), sc_w[k], sc_m[k]);
      chk($sformatf("flush_cnt[%0d]", k), fc_w[k], fc_m[k]);
    end
  end

  task automatic apply(input vec_t v);
    @(posedge CLK); #1;
    idex_memread = v.mr;  idex_rt = v.ex_rt; ifid_rs = v.rs; ifid_rt = v.rt;
    ifid_uses_rt = v.urt; pcsrc = v.pc; dmem_wait = v.dw; imem_wait = v.iw;
    cnt_clr = v.clr;
    @(negedge CLK); #1;
  endtask

  vec_t idle, haz, v;

  initial begin
    idle = '0;
    haz  = '0; haz.mr = 1'b1; haz.ex_rt = 5'd8; haz.rs = 5'd8;

    repeat (2) @(negedge CLK);
    #1;
    chk("reset_pc_en", ctl_w[1], 0);
    chk("reset_stall_cnt", sc_w[1], 0);
    @(posedge CLK); #1 RST = 1'b0;
    apply(idle);
    chk("run_after_reset", ctl_w[0], 7'b1111100);

    // Load-use: 1 bubble on variant 0, 3 bubbles on variants 1 and 2.
    apply(haz);
    chk("lu_bubble", ctl_w[0], 7'b0011101);
    apply(idle);
    chk("lu1_done", ctl_w[0], 7'b1111100);
    chk("lu3_still", ctl_w[1], 7'b0011101);
    repeat (3) apply(idle);
    chk("lu1_stalls", sc_w[0], 1);
    chk("lu3_stalls", sc_w[1], 3);
    chk("lu3_run", ctl_w[1], 7'b1111100);

    // r0 never hazards; rt only matters when the ID instruction reads it.
    v = haz; v.ex_rt = 5'd0; v.rs = 5'd0; v.clr = 1'b1;
    apply(v);
    chk("r0_no_stall", ctl_w[1], 7'b1111100);
    v = '0; v.mr = 1'b1; v.ex_rt = 5'd5; v.rs = 5'd1; v.rt = 5'd5; v.urt = 1'b0;
    apply(v);
    chk("rt_unused", ctl_w[0], 7'b1111100);
    v.urt = 1'b1;
    apply(v);
    chk("rt_used", ctl_w[0], 7'b0011101);
    repeat (3) apply(idle);

    // Redirect on the second bubble cycle cancels the remaining stall.
    v = idle; v.clr = 1'b1;
    apply(v);
    apply(haz);
    v = idle; v.pc = 2'b01;
    apply(v);
    chk("redir_ex", ctl_w[1], 7'b1111111);
    chk("redir_id", ctl_w[2], 7'b1111110);
    apply(idle);
    chk("redir_run", ctl_w[1], 7'b1111100);
    chk("redir_flush_cnt", fc_w[1], 1);

    // dmem_wait freezes mid-stall, then the remaining bubbles resume.
    v = idle; v.clr = 1'b1;
    apply(v);
    apply(haz);
    v = idle; v.dw = 1'b1;
    repeat (4) apply(v);
    chk("dmem_freeze", ctl_w[1], 7'b0000000);
    apply(idle);
    chk("dmem_resume", ctl_w[1], 7'b0011101);
    repeat (3) apply(idle);
    chk("dmem_stalls_lu1", sc_w[0], 5);
    chk("dmem_stalls_lu3", sc_w[1], 7);

    // Priority: dmem over redirect over load-use.
    v = haz; v.pc = 2'b10; v.dw = 1'b1; v.iw = 1'b1;
    apply(v);
    v.dw = 1'b0;
    apply(v);
    chk("redir_over_lu", ctl_w[0], 7'b1111110);
    apply(idle);

    // Saturation on the 4-bit variant, then clear alongside a stall.
    v = idle; v.clr = 1'b1;
    apply(v);
    v = idle; v.iw = 1'b1;
    repeat (20) apply(v);
    apply(idle);
    chk("sat_cw4", sc_w[2], 15);
    chk("nosat_cw16", sc_w[1], 20);
    v = idle; v.iw = 1'b1; v.clr = 1'b1;
    apply(v);
    apply(idle);
    chk("clr_over_inc", sc_w[2], 0);

    // Asynchronous reset in the middle of a stall.
    apply(haz);
    apply(idle);
    RST = 1'b1;
    #1;
    chk("arst_ctl", ctl_w[1], 0);
    chk("arst_stall_cnt", sc_w[1], 0);
    chk("arst_flush_cnt", fc_w[1], 0);
    @(posedge CLK); #1 RST = 1'b0;
    apply(idle);
    chk("arst_run", ctl_w[1], 7'b1111100);
    apply(idle);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl_gen2.md
Name: hazard_ctrl_gen2

Overview:
Parametrised second-generation pipeline hazard controller for the 5-stage MIPS core, one instance per core in the dual-core build. Detects load-use hazards with configurable bubble count, generates branch/jump redirect flushes for ID- or EX-stage resolution, and freezes the pipe on memory waits. Keeps saturating stall and flush performance counters. Drives the enable and flush inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB latches.

Parameters:
REG_W, 5, register-index width
LU_STALLS, 1, bubbles inserted per load-use hazard (1..7; covers load latency above 1)
RESOLVE_STAGE, 1, stage resolving redirects: 1=ID (flush IF/ID only), 2=EX (flush IF/ID and ID/EX)
CNT_W, 16, performance-counter width

Ports:
CLK  in  1  core clock
RST  in  1  asynchronous reset, active-high
ifid_rs  in  REG_W  rs of instruction in ID
ifid_rt  in  REG_W  rt of instruction in ID
ifid_uses_rt  in  1  ID instruction reads rt as a source
idex_rt  in  REG_W  destination rt of instruction in EX
idex_memread  in  1  EX instruction is a load (dmemREN)
pcsrc  in  2  0=sequential; nonzero=taken branch/jump/jr redirect
dmem_wait  in  1  data memory not ready
imem_wait  in  1  instruction memory not ready
cnt_clr  in  1  synchronous clear of both counters
pc_en  out  1  PC update enable
ifid_en  out  1  IF/ID latch enable
idex_en  out  1  ID/EX latch enable
exmem_en  out  1  EX/MEM latch enable
memwb_en  out  1  MEM/WB latch enable
ifid_flush  out  1  IF/ID bubble insert
idex_flush  out  1  ID/EX bubble insert
stall_cnt  out  CNT_W  cycles with pc_en=0
flush_cnt  out  CNT_W  redirect cycles

Behaviour:
- Reset (asynchronous, RST=1): state=RUN, lu_cnt=0, stall_cnt=0, flush_cnt=0. While RST=1: all enables=0, all flushes=0.
- States: RUN, LU_STALL. Outputs are combinational from state and inputs. Next state and counters are registered on the CLK rising edge.
- lu_hit = idex_memread & (idex_rt!=0) & ((idex_rt==ifid_rs) | (ifid_uses_rt & idex_rt==ifid_rt)).
- Priority per cycle: dmem_wait > redirect (pcsrc!=0) > load-use (lu_hit in RUN, or state LU_STALL) > imem_wait > normal.
- dmem_wait: all five enables=0, flushes=0. State and lu_cnt hold. stall_cnt increments.
- Redirect: all enables=1, ifid_flush=1, idex_flush=(RESOLVE_STAGE==2). Next state=RUN, lu_cnt=0. flush_cnt increments.
- Load-use: pc_en=0, ifid_en=0, idex_flush=1, other enables=1.
  - From RUN with LU_STALLS>1: go to LU_STALL with lu_cnt=LU_STALLS-1.
  - In LU_STALL, same outputs. lu_cnt decrements each cycle; leave to RUN on the cycle lu_cnt==1.
  - LU_STALLS==1 never enters LU_STALL.
- imem_wait only: pc_en=0, ifid_en=0, idex_flush=1, downstream enables=1.
- Normal: all enables=1, flushes=0.
- Counters:
  - stall_cnt increments on every non-reset cycle with pc_en=0.
  - Both counters saturate at 2^CNT_W-1.
  - cnt_clr forces both to 0 and overrides increments in the same cycle.
- A new lu_hit arriving while in LU_STALL is ignored; the stall already covers it.

Decomposition:
- Shared package (cpu_types_pkg): regbits_t; a new hz_state_t enum {RUN, LU_STALL}; a pcsrc encoding constant PC_SEQ=2'b00.
- One natural sub-module: sat_counter (parameter W; inputs inc, clr; output count), instantiated twice.

Test Plan:
- Load-use, LU_STALLS=1: idex_memread=1, idex_rt=8, ifid_rs=8 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle with idex_memread=0, all enables=1; stall_cnt=1.
- Load-use, LU_STALLS=3: same hazard, load deasserted after the first cycle -> exactly 3 bubble cycles, then RUN; stall_cnt=3. idex_rt=0 with ifid_rs=0 -> no stall.
- Redirect during LU_STALL (LU_STALLS=3, pcsrc=2'b01 on the 2nd cycle) -> ifid_flush=1, all enables=1, RUN next. With RESOLVE_STAGE=2, idex_flush=1 as well; flush_cnt=1.
- dmem_wait for 4 cycles mid LU_STALL -> all enables 0 and lu_cnt frozen for 4 cycles; remaining bubbles resume afterwards; stall_cnt counts wait plus bubble cycles.
- CNT_W=4: 20 stall cycles -> stall_cnt holds 15. cnt_clr together with a stall -> 0.
- RST asserted asynchronously mid LU_STALL -> outputs immediately 0, counters 0. After RST release, state RUN and all enables=1 on the first cycle with no hazard.
